// File: rtl/serial_frame_loader.sv
// rtl/serial_frame_loader.sv - serial-to-parallel frame loader with bit-reversed ping-pong banks
module serial_frame_loader #(
    parameter int SAMPLE_W = 12,
    parameter int FRAME_N  = 16,
    parameter int ADDR_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in,
    input  logic                in_en,
    output logic                frame_valid,
    input  logic                frame_ack,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [SAMPLE_W-1:0] rd_data,
    output logic                overflow
);

    localparam int CNT_W = $clog2(SAMPLE_W);

    logic [SAMPLE_W-1:0] shift_reg;
    logic [CNT_W-1:0]    bit_cnt;
    logic [ADDR_W-1:0]   sample_cnt;
    logic                wr_bank;
    logic                rd_bank;
    logic [1:0]          full;
    logic                discard;

    logic [SAMPLE_W-1:0] mem [0:2*FRAME_N-1];

    logic                last_bit;
    logic                frame_start;
    logic                drop;
    logic [SAMPLE_W-1:0] word;
    logic                wr_en;
    logic                complete;
    logic                ack;
    logic [1:0]          full_nxt;
    logic                rd_bank_nxt;

    // Reverses the address bits so samples land in radix-2 DIT order.
    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = a[ADDR_W-1-i];
        end
        return r;
    endfunction

    // Write-side decode and next bank occupancy; ack is applied before completion
    // so a same-cycle ack and completion both land without losing a frame.
    always_comb begin
        last_bit    = (bit_cnt == CNT_W'(SAMPLE_W - 1));
        frame_start = in_en && (bit_cnt == '0) && (sample_cnt == '0);
        // The drop decision for a frame is taken on its very first bit.
        drop        = frame_start ? full[wr_bank] : discard;
        word        = {shift_reg[SAMPLE_W-2:0], in};
        wr_en       = in_en && last_bit && !drop;
        complete    = wr_en && (sample_cnt == ADDR_W'(FRAME_N - 1));
        ack         = frame_ack && frame_valid;
        full_nxt    = full;
        rd_bank_nxt = rd_bank;
        if (ack) begin
            full_nxt[rd_bank] = 1'b0;
            rd_bank_nxt       = ~rd_bank;
        end
        if (complete) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    // Deserialiser counters, bank bookkeeping and presentation flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg   <= '0;
            bit_cnt     <= '0;
            sample_cnt  <= '0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            full        <= 2'b00;
            discard     <= 1'b0;
            overflow    <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            if (in_en) begin
                shift_reg <= word;
                if (frame_start) begin
                    discard <= full[wr_bank];
                    if (full[wr_bank]) begin
                        overflow <= 1'b1;
                    end
                end
                if (last_bit) begin
                    bit_cnt    <= '0;
                    sample_cnt <= (sample_cnt == ADDR_W'(FRAME_N - 1)) ? '0 : sample_cnt + 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
                if (complete) begin
                    wr_bank <= ~wr_bank;
                end
            end
            full        <= full_nxt;
            rd_bank     <= rd_bank_nxt;
            frame_valid <= full_nxt[rd_bank_nxt];
        end
    end

    // Sample store into the active write bank at the bit-reversed slot.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, bitrev(sample_cnt)}] <= word;
        end
    end

    // Registered read port; an empty bank reads as zero so unwritten words never leak out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= full[rd_bank] ? mem[{rd_bank, rd_addr}] : '0;
        end
    end

endmodule

// File: tb/tb_serial_frame_loader.sv
// tb/tb_serial_frame_loader.sv - directed self-checking bench for serial_frame_loader
module tb_serial_frame_loader;

    logic        clk;
    logic        rst;
    logic        in;
    logic        in_en;
    logic        frame_valid;
    logic        frame_ack;
    logic [3:0]  rd_addr;
    logic [11:0] rd_data;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame A in arrival order and its expected buffer-order readout.
    int seq_a[16]  = '{50, 115, 43, 20, 2, 13, 115, 20, 200, 46, 80, 92, 73, 62, 900, 1};
    int exp_rd[16] = '{50, 200, 2, 73, 43, 80, 115, 900, 115, 46, 13, 62, 20, 92, 20, 1};

    serial_frame_loader dut (
        .clk         (clk),
        .rst         (rst),
        .in          (in),
        .in_en       (in_en),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .overflow    (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: inputs set, then sample 1 ns after the rising edge.
    task automatic step(input logic b, input logic en);
        in    = b;
        in_en = en;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic ack_step();
        frame_ack = 1'b1;
        step(1'b0, 1'b0);
        frame_ack = 1'b0;
    endtask

    // Sends bits hi..lo of a sample, MSB first; toggle inserts an idle cycle after each bit.
    task automatic send_bits(input int val, input int hi, input int lo, input bit toggle);
        logic [11:0] v;
        v = 12'(val);
        for (int i = hi; i >= lo; i--) begin
            step(v[i], 1'b1);
            if (toggle) step(1'b0, 1'b0);
        end
    endtask

    // Sends a frame minus its final bit; the caller sends the final bit.
    task automatic send_frame_but_last(input bit zero, input bit toggle);
        for (int s = 0; s < 15; s++) begin
            send_bits(zero ? 0 : seq_a[s], 11, 0, toggle);
        end
        send_bits(zero ? 0 : seq_a[15], 11, 1, toggle);
    endtask

    task automatic send_frame(input bit zero);
        send_frame_but_last(zero, 1'b0);
        send_bits(zero ? 0 : seq_a[15], 0, 0, 1'b0);
    endtask

    task automatic read_frame(input string tag, input bit zero);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            step(1'b0, 1'b0);
            check_val($sformatf("%s_addr%0d", tag, i), rd_data, zero ? 0 : exp_rd[i]);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in        = 1'b0;
        in_en     = 1'b0;
        frame_ack = 1'b0;
        rd_addr   = 4'd0;
        #2;
        check_val("reset_valid", frame_valid, 0);
        check_val("reset_overflow", overflow, 0);
        check_val("reset_rd_data", rd_data, 0);
        do_reset();

        // Continuous stream: valid must appear right after the 192nd bit edge.
        send_frame_but_last(1'b0, 1'b0);
        check_val("s1_valid_before_last", frame_valid, 0);
        send_bits(seq_a[15], 0, 0, 1'b0);
        check_val("s1_valid_after_last", frame_valid, 1);
        read_frame("s1", 1'b0);

        // Ack frees the bank; second frame is zeros and no overflow.
        ack_step();
        check_val("s2_valid_after_ack", frame_valid, 0);
        send_frame(1'b1);
        check_val("s2_valid", frame_valid, 1);
        read_frame("s2", 1'b1);
        check_val("s2_overflow", overflow, 0);
        ack_step();
        check_val("s2_valid_after_ack2", frame_valid, 0);

        // Three frames without ack: the third is discarded.
        do_reset();
        send_frame(1'b0);
        send_frame(1'b1);
        check_val("s3_overflow_before", overflow, 0);
        send_bits(seq_a[0], 11, 11, 1'b0);
        check_val("s3_overflow_set", overflow, 1);
        send_bits(seq_a[0], 10, 0, 1'b0);
        for (int s = 1; s < 16; s++) send_bits(seq_a[s], 11, 0, 1'b0);
        check_val("s3_valid", frame_valid, 1);
        read_frame("s3_first", 1'b0);
        ack_step();
        check_val("s3_valid_next_bank", frame_valid, 1);
        read_frame("s3_second", 1'b1);
        ack_step();
        check_val("s3_third_absent", frame_valid, 0);
        check_val("s3_overflow_sticky", overflow, 1);

        // Async reset mid-sample clears outputs without a clock edge.
        send_frame(1'b0);
        check_val("s5_valid_pre", frame_valid, 1);
        rd_addr = 4'd0;
        step(1'b0, 1'b0);
        check_val("s5_rd_pre", rd_data, 50);
        send_bits(seq_a[0], 11, 0, 1'b0);
        send_bits(seq_a[1], 11, 6, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_val("s5_async_valid", frame_valid, 0);
        check_val("s5_async_overflow", overflow, 0);
        check_val("s5_async_rd_data", rd_data, 0);
        step(1'b0, 1'b0);
        rst = 1'b0;
        send_frame(1'b0);
        check_val("s5_restart_valid", frame_valid, 1);
        read_frame("s5_restart", 1'b0);

        // in_en toggled every cycle: same data, valid after 192 consumed bits.
        do_reset();
        send_frame_but_last(1'b0, 1'b1);
        check_val("s4_valid_before_last", frame_valid, 0);
        send_bits(seq_a[15], 0, 0, 1'b0);
        check_val("s4_valid_after_last", frame_valid, 1);
        read_frame("s4", 1'b0);

        // Ack on the same edge that completes frame 2.
        do_reset();
        send_frame(1'b0);
        send_frame_but_last(1'b1, 1'b0);
        frame_ack = 1'b1;
        step(1'b0, 1'b1);
        frame_ack = 1'b0;
        check_val("s6_valid_held", frame_valid, 1);
        check_val("s6_overflow", overflow, 0);
        read_frame("s6_second", 1'b1);
        ack_step();
        check_val("s6_valid_drained", frame_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_frame_loader.md
Name: serial_frame_loader

Overview:
- Upstream stage of the dsp block.
- Deserialises the 1-bit sample stream into 12-bit samples and stores each 16-sample frame in bit-reversed (radix-2 DIT) order.
- Presents completed frames to the FFT core through a read port and a valid/ack handshake.
- Ping-pong double buffering lets input keep streaming while the core processes the previous frame.

Parameters:
- SAMPLE_W, 12, bits per sample.
- FRAME_N, 16, samples per frame; must be a power of two.
- ADDR_W, 4, log2(FRAME_N).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- in  input  1  serial sample bit.
- in_en  input  1  qualifies in; a bit is consumed only on a clk edge with in_en=1.
- frame_valid  output  1  a complete frame is readable.
- frame_ack  input  1  one-cycle pulse; consumer releases the presented frame.
- rd_addr  input  ADDR_W  buffer-order read address into the presented frame.
- rd_data  output  SAMPLE_W  registered read data.
- overflow  output  1  sticky; a frame was discarded for lack of a free bank.

Behaviour:
- Reset (async, any time, including mid-frame):
  - bit_cnt, sample_cnt, wr_bank and rd_bank = 0.
  - Both banks empty.
  - frame_valid, rd_data and overflow = 0.
  - Any partial frame is discarded.
- Serial format:
  - First bit received is the sample MSB, i.e. index 0 of a [0:SAMPLE_W-1] vector.
  - The shift register shifts left each consumed bit.
  - bit_cnt wraps SAMPLE_W-1 -> 0.
- Sample write:
  - On the consumed bit with bit_cnt=SAMPLE_W-1, the assembled word (including that final bit) is written to wr_bank at address bitrev(sample_cnt).
  - bitrev reverses the ADDR_W bits, so sample 8 lands at address 1.
  - sample_cnt increments and wraps FRAME_N-1 -> 0.
- Frame start:
  - On the first consumed bit of sample 0, the writer latches whether wr_bank is empty.
  - If it is not empty, the whole frame is discarded: bits are still counted so alignment is kept, no memory writes occur, and overflow sets and stays set until rst.
- Frame completion:
  - Triggered by the final bit of sample FRAME_N-1 in a stored frame.
  - wr_bank is marked full.
  - wr_bank toggles.
- Read side:
  - frame_valid = (rd_bank full), registered.
  - It rises the cycle after the completing bit edge.
  - rd_data <= mem[rd_bank][rd_addr] every cycle, giving 1-cycle latency.
  - rd_data is don't-care when frame_valid=0 but must not be X after reset.
- Ack:
  - frame_ack while frame_valid=1 marks rd_bank empty and toggles rd_bank.
  - frame_valid is then 0 on the next cycle, unless the other bank is full, in which case it stays 1 and the new bank is presented.
  - frame_ack while frame_valid=0 is ignored.
- Simultaneous ack and completion in the same cycle: both take effect, with no lost or duplicated frame.
- Ordering: frames are presented in completion order; there is never more than 2 full banks.
- in_en=0: all write-side state holds; the read side is unaffected.
- Memory: 2*FRAME_N x SAMPLE_W, with one synchronous write port and one synchronous read port.

Test Plan:
- Continuous in_en=1, 32-sample repeating stream (16 values 50,115,43,20,2,13,115,20,200,46,80,92,73,62,900,1 then 16 zeros), MSB-first:
  - frame_valid rises exactly 1 cycle after the 192nd bit edge.
  - rd_addr 0..15 returns 50,200,2,73,43,80,115,900,115,46,13,62,20,92,20,1, each 1 cycle after its address.
- Same stream with ack after the first frame: the second frame reads all 0; overflow stays 0.
- No ack for 3 frames:
  - overflow=1 after the third frame's first bit.
  - The first frame still reads the sequence above.
  - After ack, the zero frame is presented.
  - The third frame never appears.
- in_en toggled 1/0 every cycle: same data as the first scenario; frame_valid rises after 192 consumed bits (about 384 cycles).
- rst pulsed mid-sample of frame 1:
  - All outputs are 0 immediately, without waiting for a clk edge.
  - Restarting the stream yields the correct first frame.
- frame_ack asserted on the same edge as frame 2 completes while frame 1 is presented: frame_valid stays 1, frame 2 is presented next, and overflow=0.
